// File: rtl/eth_udp_ctrl_regbank_if.sv
// AXI4-Lite bus bundle for the eth_udp_stack control register bank.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R).
// The slave modport is used by the register bank. The master modport is
// used by whatever drives it: the interconnect, or a testbench.
interface eth_udp_ctrl_regbank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/eth_udp_ctrl_regbank.sv
// AXI4-Lite slave register bank for the eth_udp_stack control path.
//
// Word map, where N = NUM_RW + NUM_RO:
//   idx 0 .. NUM_RW-1 : CTRL registers (read/write).
//   NUM_RW .. N-1     : STATUS registers (read-only).
//   N                 : EVT_STAT (write 1 to clear).
//   N+1               : EVT_EN (read/write).
//   Anything above    : unmapped, answered with SLVERR.
//
// Ports:
//   ACLK, ARESETN : single clock; asynchronous, active-low reset.
//   s_axi         : AXI4-Lite slave channels.
//   ctrl_o        : CTRL contents; register k is at [k*DATA_WIDTH +: DATA_WIDTH].
//   ctrl_wr_o     : one-cycle pulse per CTRL register on each accepted write to it.
//   status_i      : STATUS values, sampled when the read address is accepted.
//   evt_i         : event strobes, level-sampled into EVT_STAT every cycle.
//   irq_o         : registered OR of (EVT_STAT & EVT_EN).
module eth_udp_ctrl_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_RW     = 4,
  parameter int NUM_RO     = 2,
  parameter int EVT_WIDTH  = 8
) (
  input  logic                                          ACLK,
  input  logic                                          ARESETN,
  eth_udp_ctrl_regbank_if.slave                         s_axi,
  output logic [NUM_RW*DATA_WIDTH-1:0]                  ctrl_o,
  output logic [NUM_RW-1:0]                             ctrl_wr_o,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] status_i,
  input  logic [EVT_WIDTH-1:0]                          evt_i,
  output logic                                          irq_o
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [IDX_W-1:0] IDX_STAT = IDX_W'(NUM_RW + NUM_RO);
  localparam logic [IDX_W-1:0] IDX_EN   = IDX_W'(NUM_RW + NUM_RO + 1);

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_GOT_AW = 2'd1;
  localparam logic [1:0] W_GOT_W  = 2'd2;
  localparam logic [1:0] W_RESP   = 2'd3;
  localparam logic [0:0] R_IDLE   = 1'b0;
  localparam logic [0:0] R_DATA   = 1'b1;

  // Replace each byte lane whose strobe is set.
  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

  logic [1:0]              w_state, w_state_nxt;
  logic [0:0]              r_state, r_state_nxt;
  logic                    aw_ready, w_ready, ar_ready, b_valid, r_valid;
  logic [1:0]              b_resp, r_resp, rd_resp;
  logic [DATA_WIDTH-1:0]   r_data, rd_data;
  logic [ADDR_WIDTH-1:0]   aw_addr_hold, wr_addr;
  logic [DATA_WIDTH-1:0]   w_data_hold, wr_data;
  logic [STRB_W-1:0]       w_strb_hold, wr_strb;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic                    aw_hs, w_hs, ar_hs, wr_commit;
  logic [NUM_RW*DATA_WIDTH-1:0] ctrl_reg;
  logic [NUM_RW-1:0]       ctrl_wr, ctrl_wr_pulse;
  logic [EVT_WIDTH-1:0]    evt_stat, evt_en, evt_clr;
  logic                    irq;
  logic                    addr_lsb_unused;

  assign s_axi.awready = aw_ready;
  assign s_axi.wready  = w_ready;
  assign s_axi.bvalid  = b_valid;
  assign s_axi.bresp   = b_resp;
  assign s_axi.arready = ar_ready;
  assign s_axi.rvalid  = r_valid;
  assign s_axi.rresp   = r_resp;
  assign s_axi.rdata   = r_data;
  assign ctrl_o        = ctrl_reg;
  assign ctrl_wr_o     = ctrl_wr;
  assign irq_o         = irq;

  assign aw_hs = s_axi.awvalid & aw_ready;
  assign w_hs  = s_axi.wvalid  & w_ready;
  assign ar_hs = s_axi.arvalid & ar_ready;

  // The channel that completes the pair is taken live; the other comes from its hold register.
  assign wr_addr = (w_state == W_GOT_AW) ? aw_addr_hold : s_axi.awaddr;
  assign wr_data = (w_state == W_GOT_W)  ? w_data_hold  : s_axi.wdata;
  assign wr_strb = (w_state == W_GOT_W)  ? w_strb_hold  : s_axi.wstrb;
  assign wr_idx  = wr_addr[ADDR_WIDTH-1:ADDR_LSB];
  assign rd_idx  = s_axi.araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign addr_lsb_unused = ^{wr_addr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

  // Write FSM next state; the commit fires on the cycle the second channel handshakes.
  always_comb begin
    w_state_nxt = w_state;
    wr_commit   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_state_nxt = W_RESP;
          wr_commit   = 1'b1;
        end else if (aw_hs) begin
          w_state_nxt = W_GOT_AW;
        end else if (w_hs) begin
          w_state_nxt = W_GOT_W;
        end else begin
          w_state_nxt = W_IDLE;
        end
      end
      W_GOT_AW: begin
        if (w_hs) begin
          w_state_nxt = W_RESP;
          wr_commit   = 1'b1;
        end else begin
          w_state_nxt = W_GOT_AW;
        end
      end
      W_GOT_W: begin
        if (aw_hs) begin
          w_state_nxt = W_RESP;
          wr_commit   = 1'b1;
        end else begin
          w_state_nxt = W_GOT_W;
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          w_state_nxt = W_IDLE;
        end else begin
          w_state_nxt = W_RESP;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write FSM state, registered handshake outputs and channel hold registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state      <= W_IDLE;
      aw_ready     <= 1'b0;
      w_ready      <= 1'b0;
      b_valid      <= 1'b0;
      b_resp       <= 2'b00;
      aw_addr_hold <= '0;
      w_data_hold  <= '0;
      w_strb_hold  <= '0;
    end else begin
      w_state  <= w_state_nxt;
      aw_ready <= (w_state_nxt == W_IDLE) || (w_state_nxt == W_GOT_W);
      w_ready  <= (w_state_nxt == W_IDLE) || (w_state_nxt == W_GOT_AW);
      b_valid  <= (w_state_nxt == W_RESP);
      if (aw_hs) aw_addr_hold <= s_axi.awaddr;
      if (w_hs) begin
        w_data_hold <= s_axi.wdata;
        w_strb_hold <= s_axi.wstrb;
      end
      if (wr_commit) b_resp <= (wr_idx > IDX_EN) ? 2'b10 : 2'b00;
    end
  end

  // Per-register write strobes and W1C clear mask for the commit cycle.
  always_comb begin
    ctrl_wr_pulse = '0;
    evt_clr       = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      ctrl_wr_pulse[k] = wr_commit && (wr_idx == IDX_W'(k));
    end
    for (int i = 0; i < EVT_WIDTH; i++) begin
      evt_clr[i] = wr_commit && (wr_idx == IDX_STAT) && wr_strb[i/8] && wr_data[i];
    end
  end

  // Register contents: CTRL and EVT_EN byte writes, and EVT_STAT where a set beats a clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_reg <= '0;
      ctrl_wr  <= '0;
      evt_stat <= '0;
      evt_en   <= '0;
      irq      <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_RW; k++) begin
        if (ctrl_wr_pulse[k]) begin
          ctrl_reg[k*DATA_WIDTH +: DATA_WIDTH] <=
            byte_merge(ctrl_reg[k*DATA_WIDTH +: DATA_WIDTH], wr_data, wr_strb);
        end
      end
      for (int i = 0; i < EVT_WIDTH; i++) begin
        if (wr_commit && (wr_idx == IDX_EN) && wr_strb[i/8]) evt_en[i] <= wr_data[i];
      end
      ctrl_wr  <= ctrl_wr_pulse;
      evt_stat <= (evt_stat & ~evt_clr) | evt_i;
      irq      <= |(evt_stat & evt_en);
    end
  end

  // Read data selection; it sees register values from before any write committing this cycle.
  always_comb begin
    rd_data = '0;
    rd_resp = 2'b00;
    for (int k = 0; k < NUM_RW; k++) begin
      rd_data = (rd_idx == IDX_W'(k)) ? ctrl_reg[k*DATA_WIDTH +: DATA_WIDTH] : rd_data;
    end
    for (int k = 0; k < NUM_RO; k++) begin
      rd_data = (rd_idx == IDX_W'(NUM_RW + k)) ? status_i[k*DATA_WIDTH +: DATA_WIDTH] : rd_data;
    end
    if (rd_idx == IDX_STAT) begin
      rd_data = DATA_WIDTH'(evt_stat);
    end else if (rd_idx == IDX_EN) begin
      rd_data = DATA_WIDTH'(evt_en);
    end else if (rd_idx > IDX_EN) begin
      rd_resp = 2'b10;
    end else begin
      rd_resp = 2'b00;
    end
  end

  // Read FSM next state.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) r_state_nxt = R_DATA;
        else       r_state_nxt = R_IDLE;
      end
      R_DATA: begin
        if (s_axi.rready) r_state_nxt = R_IDLE;
        else              r_state_nxt = R_DATA;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read FSM state and registered read response, held until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state  <= R_IDLE;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_resp   <= 2'b00;
    end else begin
      r_state  <= r_state_nxt;
      ar_ready <= (r_state_nxt == R_IDLE);
      r_valid  <= (r_state_nxt == R_DATA);
      if (ar_hs) begin
        r_data <= rd_data;
        r_resp <= rd_resp;
      end
    end
  end
endmodule

// File: tb/tb_eth_udp_ctrl_regbank.sv
// Scoreboard testbench for eth_udp_ctrl_regbank (32-bit data, 4 CTRL, 2 STATUS, 8 events).
module tb_eth_udp_ctrl_regbank;
  localparam int DW = 32, AW = 8, NUM_RW = 4, NUM_RO = 2, EVT_W = 8;

  logic                   clk, rst_n;
  logic [NUM_RO*DW-1:0]   status_i;
  logic [EVT_W-1:0]       evt_i;
  logic [NUM_RW*DW-1:0]   ctrl_o;
  logic [NUM_RW-1:0]      ctrl_wr_o;
  logic                   irq_o;

  eth_udp_ctrl_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  eth_udp_ctrl_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RW(NUM_RW),
                         .NUM_RO(NUM_RO), .EVT_WIDTH(EVT_W)) dut (
    .ACLK(clk), .ARESETN(rst_n), .s_axi(axi), .ctrl_o(ctrl_o),
    .ctrl_wr_o(ctrl_wr_o), .status_i(status_i), .evt_i(evt_i), .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Reference model state
  logic [31:0] m_ctrl [NUM_RW];
  logic [7:0]  m_stat, m_en;
  int          m_wr_cnt [NUM_RW];
  int          seen_wr_cnt [NUM_RW];
  logic [1:0]  q_bresp [$];
  logic [31:0] q_rdata [$];
  logic [1:0]  q_rresp [$];
  logic        irq_first;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got event/timeout expected none", name);
  endtask

  function automatic logic [127:0] model_ctrl_vec();
    logic [127:0] v;
    for (int k = 0; k < NUM_RW; k++) v[k*32 +: 32] = m_ctrl[k];
    return v;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = strb[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Apply a write to the model; returns the expected BRESP.
  function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int idx;
    logic [31:0] m, en32;
    idx = int'(addr) / 4;
    m = strb_mask(strb);
    if (idx < NUM_RW) begin
      m_ctrl[idx] = (m_ctrl[idx] & ~m) | (data & m);
      m_wr_cnt[idx]++;
      return 2'b00;
    end else if (idx < NUM_RW + NUM_RO) begin
      return 2'b00;
    end else if (idx == NUM_RW + NUM_RO) begin
      m = data & m;
      m_stat = m_stat & ~m[7:0];
      return 2'b00;
    end else if (idx == NUM_RW + NUM_RO + 1) begin
      en32 = ({24'h0, m_en} & ~m) | (data & m);
      m_en = en32[7:0];
      return 2'b00;
    end else begin
      return 2'b10;
    end
  endfunction

  task automatic model_read(input logic [7:0] addr, output logic [31:0] d, output logic [1:0] r);
    int idx;
    idx = int'(addr) / 4;
    r = 2'b00;
    if (idx < NUM_RW)                        d = m_ctrl[idx];
    else if (idx < NUM_RW + NUM_RO)          d = status_i[(idx-NUM_RW)*32 +: 32];
    else if (idx == NUM_RW + NUM_RO)         d = {24'h0, m_stat};
    else if (idx == NUM_RW + NUM_RO + 1)     d = {24'h0, m_en};
    else begin d = 32'h0; r = 2'b10; end
  endtask

  // Monitor: pops the scoreboard whenever a response handshake is visible.
  always @(negedge clk) begin
    if (rst_n) begin
      if (axi.bvalid && axi.bready) begin
        if (q_bresp.size() == 0) fail_now("unexpected_bvalid");
        else begin
          chk("bresp", axi.bresp, q_bresp.pop_front());
          chk("ctrl_o", ctrl_o, model_ctrl_vec());
        end
      end
      if (axi.rvalid && axi.rready) begin
        if (q_rdata.size() == 0) fail_now("unexpected_rvalid");
        else begin
          chk("rdata", axi.rdata, q_rdata.pop_front());
          chk("rresp", axi.rresp, q_rresp.pop_front());
        end
      end
      for (int k = 0; k < NUM_RW; k++) if (ctrl_wr_o[k]) seen_wr_cnt[k]++;
    end
  end

  // order: 0 = AW and W together, 1 = AW first, 2 = W first; gap cycles between them.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int order, input int gap, input int bdelay);
    bit aw_done, w_done, aw_f, w_f, got;
    int aw_start, w_start;
    q_bresp.push_back(model_write(addr, data, strb));
    axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
    aw_done = 0; w_done = 0;
    aw_start = (order == 2) ? gap : 0;
    w_start  = (order == 1) ? gap : 0;
    for (int c = 0; c < 60 && !(aw_done && w_done); c++) begin
      if (!aw_done && c >= aw_start) axi.awvalid = 1'b1;
      if (!w_done && c >= w_start)   axi.wvalid  = 1'b1;
      @(negedge clk);
      aw_f = axi.awvalid && axi.awready;
      w_f  = axi.wvalid && axi.wready;
      @(posedge clk); #1;
      if (aw_f) begin axi.awvalid = 1'b0; aw_done = 1; end
      if (w_f)  begin axi.wvalid  = 1'b0; w_done  = 1; end
    end
    if (!(aw_done && w_done)) begin
      fail_now("aw_w_timeout");
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      return;
    end
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (axi.bvalid) got = 1;
    end
    if (!got) begin fail_now("bvalid_timeout"); return; end
    irq_first = irq_o;
    for (int i = 0; i < bdelay; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bvalid_hold", axi.bvalid, 1'b1);
      chk("awready_in_resp", axi.awready, 1'b0);
    end
    @(posedge clk); #1 axi.bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 axi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, input int rdelay);
    logic [31:0] d; logic [1:0] r;
    bit fire, got;
    model_read(addr, d, r);
    q_rdata.push_back(d); q_rresp.push_back(r);
    axi.araddr = addr; axi.arvalid = 1'b1;
    fire = 0;
    for (int c = 0; c < 20 && !fire; c++) begin
      @(negedge clk);
      fire = axi.arready;
      @(posedge clk); #1;
    end
    axi.arvalid = 1'b0;
    if (!fire) begin fail_now("ar_timeout"); return; end
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (axi.rvalid) got = 1;
    end
    if (!got) begin fail_now("rvalid_timeout"); return; end
    for (int i = 0; i < rdelay; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rvalid_hold", axi.rvalid, 1'b1);
      chk("rdata_hold", axi.rdata, q_rdata[0]);
      chk("arready_in_data", axi.arready, 1'b0);
    end
    @(posedge clk); #1 axi.rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 axi.rready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, axi.awready, 1'b0);
    chk({tag, "_wready"},  axi.wready,  1'b0);
    chk({tag, "_arready"}, axi.arready, 1'b0);
    chk({tag, "_bvalid"},  axi.bvalid,  1'b0);
    chk({tag, "_rvalid"},  axi.rvalid,  1'b0);
    chk({tag, "_bresp"},   axi.bresp,   2'b00);
    chk({tag, "_rresp"},   axi.rresp,   2'b00);
    chk({tag, "_rdata"},   axi.rdata,   32'h0);
    chk({tag, "_ctrl_o"},  ctrl_o,      128'h0);
    chk({tag, "_ctrl_wr"}, ctrl_wr_o,   4'h0);
    chk({tag, "_irq"},     irq_o,       1'b0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_RW; k++) m_ctrl[k] = 32'h0;
    m_stat = 8'h0; m_en = 8'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] addr; int idx;
    axi.awaddr = 8'h0; axi.awvalid = 1'b0; axi.wdata = 32'h0; axi.wstrb = 4'h0;
    axi.wvalid = 1'b0; axi.bready = 1'b0; axi.araddr = 8'h0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    status_i = {32'hCAFE0001, 32'h5A5A1234};
    evt_i = 8'h0;
    model_reset();
    for (int k = 0; k < NUM_RW; k++) begin m_wr_cnt[k] = 0; seen_wr_cnt[k] = 0; end

    // Asynchronous reset before the first clock edge.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write/readback of all CTRL registers.
    for (int k = 0; k < 4; k++) axi_write(8'(k*4), 32'(k+1), 4'hF, 0, 0, 0);
    for (int k = 0; k < 4; k++) axi_read(8'(k*4), 0);

    // Byte strobes, with AW and W arriving together and with W two cycles ahead.
    axi_write(8'h04, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(8'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    axi_read(8'h04, 0);
    axi_write(8'h04, 32'h11223344, 4'hF, 1, 1, 0);
    axi_write(8'h04, 32'hAABBCCDD, 4'b0101, 2, 2, 0);
    axi_read(8'h04, 0);

    // STATUS is read-only.
    axi_read(8'h14, 0);
    axi_write(8'h14, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_read(8'h14, 0);
    axi_read(8'h10, 0);

    // Events, enable mask and interrupt.
    axi_write(8'h1C, 32'h00000001, 4'hF, 0, 0, 0);
    evt_i = 8'h01; m_stat = m_stat | 8'h01;
    @(posedge clk); #1 evt_i = 8'h00;
    @(posedge clk); #1;
    @(negedge clk);
    chk("irq_set", irq_o, |(m_stat & m_en));
    @(posedge clk); #1;
    axi_read(8'h18, 0);
    evt_i = 8'h01;
    axi_write(8'h18, 32'h00000001, 4'hF, 0, 0, 1);
    evt_i = 8'h00; m_stat = m_stat | 8'h01;
    axi_read(8'h18, 0);
    axi_write(8'h18, 32'h00000001, 4'hF, 0, 0, 1);
    chk("irq_lags_clear", irq_first, 1'b1);
    @(negedge clk);
    chk("irq_cleared", irq_o, |(m_stat & m_en));
    @(posedge clk); #1;
    axi_read(8'h18, 0);
    axi_read(8'h1C, 0);

    // Unmapped addresses.
    axi_read(8'h40, 0);
    axi_write(8'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(8'h00, 0);

    // Responses held while BREADY/RREADY stay low.
    axi_write(8'h08, 32'h0BADF00D, 4'hF, 1, 0, 5);
    axi_read(8'h08, 5);

    // Randomised traffic, including unmapped indices and ignored low address bits.
    for (int it = 0; it < 40; it++) begin
      idx  = $urandom_range(0, 9);
      addr = 8'(idx*4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        axi_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(addr, $urandom_range(0, 3));
      @(negedge clk);
      chk("irq_random", irq_o, |(m_stat & m_en));
      @(posedge clk); #1;
    end

    // Reset with a write response and a read response both pending.
    axi.awaddr = 8'h00; axi.wdata = 32'h12345678; axi.wstrb = 4'hF; axi.araddr = 8'h00;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
    @(negedge clk);
    chk("mid_aw_ready", axi.awready && axi.wready && axi.arready, 1'b1);
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    m_wr_cnt[0]++;
    @(negedge clk);
    chk("mid_bvalid", axi.bvalid, 1'b1);
    chk("mid_rvalid", axi.rvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    model_reset();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) axi_read(8'(k*4), 0);
    axi_write(8'h0C, 32'hA5A5A5A5, 4'b1100, 2, 1, 0);
    axi_read(8'h0C, 0);

    repeat (3) @(posedge clk);
    for (int k = 0; k < NUM_RW; k++) chk("ctrl_wr_count", seen_wr_cnt[k], m_wr_cnt[k]);
    chk("bresp_queue_empty", q_bresp.size(), 0);
    chk("rdata_queue_empty", q_rdata.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
